// File: rtl/audit_event_arbiter.sv
// -----------------------------------------------------------------------------
// audit_event_arbiter
//
// Round-robin arbiter that collects audit events from NUM_REQ requesters and
// forwards one event at a time to an audit logging engine. Each forwarded
// event is tagged with the winning requester index, a 32-bit sequence number
// and a 64-bit grant-time timestamp.
//
// Two-state FSM:
//   IDLE - pick a winner among req_valid and pulse its req_ready for one cycle.
//          The winner's payload is captured on that same edge.
//   SEND - hold log_valid and log_* stable until log_ready is seen.
//
// Optional feature (compile-time macro AUDIT_ARB_TIMEOUT_EN):
//   When defined, a SEND that lasts TIMEOUT_CYC cycles without log_ready
//   drops the event. timeout_pulse goes high for one cycle, drop_count
//   increments and saturates, and the sequence number is not consumed.
//   When undefined, SEND waits forever and timeout_pulse/drop_count are 0.
//
// Parameters:
//   NUM_REQ     - number of requesters (2..8)
//   TIMEOUT_CYC - SEND watchdog limit in cycles (used with AUDIT_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   req_valid      - per-requester event pending
//   req_ready      - one-hot grant (combinational, IDLE only)
//   req_did/data/res - packed per-requester payloads, slot i at [i*W +: W]
//   log_valid/ready  - handshake towards the logging engine
//   log_did/data/res - captured payload of the current event
//   log_src        - winning requester index
//   log_seq        - event sequence number
//   log_timestamp  - free-running cycle count at grant time
//   busy           - high while in SEND
//   timeout_pulse  - one-cycle pulse when an event is dropped
//   drop_count     - saturating count of dropped events
// -----------------------------------------------------------------------------
module audit_event_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*128-1:0]   req_did,
  input  logic [NUM_REQ*256-1:0]   req_data,
  input  logic [NUM_REQ*256-1:0]   req_res,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [127:0]             log_did,
  output logic [255:0]             log_data,
  output logic [255:0]             log_res,
  output logic [2:0]               log_src,
  output logic [31:0]              log_seq,
  output logic [63:0]              log_timestamp,
  output logic                     busy,
  output logic                     timeout_pulse,
  output logic [15:0]              drop_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("audit_event_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]    seq_cnt_q, seq_cnt_d;
  logic [63:0]    ts_cnt_q, ts_cnt_d;
  logic           log_valid_q, log_valid_d;
  logic [127:0]   log_did_q, log_did_d;
  logic [255:0]   log_data_q, log_data_d;
  logic [255:0]   log_res_q, log_res_d;
  logic [2:0]     log_src_q, log_src_d;
  logic [31:0]    log_seq_q, log_seq_d;
  logic [63:0]    log_ts_q, log_ts_d;

`ifdef AUDIT_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [15:0]      drop_count_q, drop_count_d;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin winner selection.
  // Rotating req_valid right by rr_ptr puts the requester at rr_ptr in bit 0,
  // so the lowest set bit of the rotated vector is the first requester at or
  // after rr_ptr (with wrap-around).
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] rot_valid;
  logic               found;
  logic [3:0]         win_sum;
  logic [2:0]         win_idx;
  logic [2:0]         next_ptr;
  logic               grant;
  logic [127:0]       sel_did;
  logic [255:0]       sel_data;
  logic [255:0]       sel_res;

  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    found     = 1'b0;
    win_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_valid[k]) begin
        found   = 1'b1;
        win_sum = {1'b0, rr_ptr_q} + 4'(k);
      end
    end
    if (win_sum >= 4'(NUM_REQ)) begin
      win_sum = win_sum - 4'(NUM_REQ);
    end
    win_idx  = win_sum[2:0];
    next_ptr = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;

    // rst_n gates the grant so req_ready reads 0 for the whole reset window.
    grant = rst_n && (state_q == IDLE) && found;

    req_ready = '0;
    sel_did   = '0;
    sel_data  = '0;
    sel_res   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == win_idx) begin
        req_ready[j] = grant;
        sel_did      = req_did[j*128 +: 128];
        sel_data     = req_data[j*256 +: 256];
        sel_res      = req_res[j*256 +: 256];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    seq_cnt_d   = seq_cnt_q;
    ts_cnt_d    = ts_cnt_q + 64'd1;  // wraps 2^64-1 -> 0 naturally
    log_valid_d = log_valid_q;
    log_did_d   = log_did_q;
    log_data_d  = log_data_q;
    log_res_d   = log_res_q;
    log_src_d   = log_src_q;
    log_seq_d   = log_seq_q;
    log_ts_d    = log_ts_q;
`ifdef AUDIT_ARB_TIMEOUT_EN
    tmo_cnt_d       = tmo_cnt_q;
    timeout_pulse_d = 1'b0;
    drop_count_d    = drop_count_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = SEND;
          log_valid_d = 1'b1;
          log_src_d   = win_idx;
          log_did_d   = sel_did;
          log_data_d  = sel_data;
          log_res_d   = sel_res;
          log_seq_d   = seq_cnt_q;
          log_ts_d    = ts_cnt_q;
          rr_ptr_d    = next_ptr;
`ifdef AUDIT_ARB_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      SEND: begin
        // The handshake is checked first so it wins over a same-cycle expiry.
        if (log_ready) begin
          state_d     = IDLE;
          log_valid_d = 1'b0;
          seq_cnt_d   = seq_cnt_q + 32'd1;
        end
`ifdef AUDIT_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d         = IDLE;
          log_valid_d     = 1'b0;
          timeout_pulse_d = 1'b1;
          if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      seq_cnt_q   <= '0;
      ts_cnt_q    <= '0;
      log_valid_q <= 1'b0;
      log_did_q   <= '0;
      log_data_q  <= '0;
      log_res_q   <= '0;
      log_src_q   <= '0;
      log_seq_q   <= '0;
      log_ts_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      seq_cnt_q   <= seq_cnt_d;
      ts_cnt_q    <= ts_cnt_d;
      log_valid_q <= log_valid_d;
      log_did_q   <= log_did_d;
      log_data_q  <= log_data_d;
      log_res_q   <= log_res_d;
      log_src_q   <= log_src_d;
      log_seq_q   <= log_seq_d;
      log_ts_q    <= log_ts_d;
    end
  end

`ifdef AUDIT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q       <= '0;
      timeout_pulse_q <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign timeout_pulse = timeout_pulse_q;
  assign drop_count    = drop_count_q;
`else
  assign timeout_pulse = 1'b0;
  assign drop_count    = 16'd0;
`endif

  assign log_valid     = log_valid_q;
  assign log_did       = log_did_q;
  assign log_data      = log_data_q;
  assign log_res       = log_res_q;
  assign log_src       = log_src_q;
  assign log_seq       = log_seq_q;
  assign log_timestamp = log_ts_q;
  assign busy          = (state_q == SEND);

endmodule

// File: tb/tb_audit_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_audit_event_arbiter
//
// Self-checking bench for audit_event_arbiter. A transaction-level reference
// model (pending event record, pointer, counters) predicts every output each
// cycle. Directed phases: reset, single request, all-request fairness,
// backpressure, sequence wrap, long stall (watchdog), random traffic and reset
// in the middle of SEND.
// -----------------------------------------------------------------------------
module tb_audit_event_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

`ifdef AUDIT_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*128-1:0]     req_did;
  logic [N*256-1:0]     req_data;
  logic [N*256-1:0]     req_res;
  logic                 log_valid;
  logic                 log_ready;
  logic [127:0]         log_did;
  logic [255:0]         log_data;
  logic [255:0]         log_res;
  logic [2:0]           log_src;
  logic [31:0]          log_seq;
  logic [63:0]          log_timestamp;
  logic                 busy;
  logic                 timeout_pulse;
  logic [15:0]          drop_count;

  audit_event_arbiter #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_did      (req_did),
    .req_data     (req_data),
    .req_res      (req_res),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_did      (log_did),
    .log_data     (log_data),
    .log_res      (log_res),
    .log_src      (log_src),
    .log_seq      (log_seq),
    .log_timestamp(log_timestamp),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]   src;
    logic [127:0] did;
    logic [255:0] data;
    logic [255:0] res;
    logic [31:0]  seq;
    logic [63:0]  ts;
  } event_t;

  event_t       m_ev;     // event currently held on log_* (last one when idle)
  bit           m_busy;
  int           m_ptr;
  int           m_wait;
  logic [31:0]  m_seq;
  logic [63:0]  m_cyc;
  logic [15:0]  m_drop;
  bit           m_pulse;

  int n_assert;
  int n_fail;
  int dut_grants[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ev    = '0;
    m_busy  = 1'b0;
    m_ptr   = 0;
    m_wait  = 0;
    m_seq   = '0;
    m_cyc   = '0;
    m_drop  = '0;
    m_pulse = 1'b0;
  endtask

  task automatic randomize_payload();
    logic [255:0] r;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < 8; c++) r[c*32 +: 32] = $urandom;
      req_did[i*128 +: 128] = r[127:0];
      for (int c = 0; c < 8; c++) r[c*32 +: 32] = $urandom;
      req_data[i*256 +: 256] = r;
      for (int c = 0; c < 8; c++) r[c*32 +: 32] = $urandom;
      req_res[i*256 +: 256] = r;
    end
  endtask

  // One clock cycle: check all outputs mid-cycle against the model, advance
  // the model by the rules of one edge, and return just after the edge.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int w;
    @(negedge clk);
    exp_rdy = '0;
    w = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;

    check("req_ready", req_ready, exp_rdy);
    check("log_valid", log_valid, m_busy);
    check("busy", busy, m_busy);
    check("log_src", log_src, m_ev.src);
    check("log_seq", log_seq, m_ev.seq);
    check("log_timestamp", log_timestamp, m_ev.ts);
    check("log_did", log_did, m_ev.did);
    check("log_data", log_data, m_ev.data);
    check("log_res", log_res, m_ev.res);
    check("timeout_pulse", timeout_pulse, m_pulse);
    check("drop_count", drop_count, m_drop);

    for (int k = 0; k < N; k++) if (req_ready[k]) dut_grants.push_back(k);

    m_pulse = 1'b0;
    if (!m_busy) begin
      if (w >= 0) begin
        m_ev.src  = 3'(w);
        m_ev.did  = req_did[w*128 +: 128];
        m_ev.data = req_data[w*256 +: 256];
        m_ev.res  = req_res[w*256 +: 256];
        m_ev.seq  = m_seq;
        m_ev.ts   = m_cyc;
        m_ptr     = (w + 1) % N;
        m_busy    = 1'b1;
        m_wait    = 0;
      end
    end else begin
      m_wait++;
      if (log_ready) begin
        m_busy = 1'b0;
        m_seq  = m_seq + 32'd1;
      end else if (TMO_EN && m_wait == TMO) begin
        m_busy  = 1'b0;
        m_pulse = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    m_cyc = m_cyc + 64'd1;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset (asynchronously, from wherever the bench is), checks the
  // forced values right away and again after a couple of edges, then releases.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_log_valid", log_valid, 1'b0);
    check("rst_req_ready", req_ready, '0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_log_seq", log_seq, '0);
    check("rst_log_src", log_src, '0);
    check("rst_log_ts", log_timestamp, '0);
    check("rst_log_data", log_data, '0);
    check("rst_drop", drop_count, '0);
    check("rst_pulse", timeout_pulse, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timed out");
  end

  initial begin
    int exp_order[5];
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    log_ready = 1'b0;
    req_did   = '0;
    req_data  = '0;
    req_res   = '0;

    // Reset with a request pending: req_ready must stay low.
    req_valid = 4'b1111;
    do_reset();
    req_valid = '0;

    // Single request from requester 2, sink always ready.
    randomize_payload();
    req_valid = 4'b0100;
    log_ready = 1'b1;
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // All requesters held: grant order continues round-robin from pointer 3.
    dut_grants.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      randomize_payload();
      cycle();
    end
    req_valid = '0;
    cycle();
    exp_order = '{3, 0, 1, 2, 3};
    for (int i = 0; i < 5; i++) check("fair_order", dut_grants[i], exp_order[i]);

    // Fresh reset, then fairness from pointer 0: order 0,1,2,3,0.
    do_reset();
    dut_grants.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      randomize_payload();
      cycle();
    end
    req_valid = '0;
    cycle();
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) check("fair_order_rst", dut_grants[i], exp_order[i]);

    // Backpressure: 10 stalled SEND cycles with inputs changing underneath.
    req_valid = 4'b1011;
    log_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      randomize_payload();
      cycle();
    end
    log_ready = 1'b1;
    req_valid = '0;
    repeat (3) cycle();

    // Sequence wrap: hold the counter at all-ones across an edge, then let go.
    force dut.seq_cnt_q = 32'hFFFF_FFFF;
    repeat (2) cycle();
    release dut.seq_cnt_q;
    m_seq = 32'hFFFF_FFFF;
    req_valid = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      randomize_payload();
      cycle();
    end
    req_valid = '0;
    cycle();

    // Long stall: drops and regrants when the watchdog is built in,
    // otherwise the event simply waits.
    req_valid = 4'b0001;
    log_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      randomize_payload();
      cycle();
    end
    log_ready = 1'b1;
    req_valid = '0;
    repeat (3) cycle();

    // Handshake on the very last watchdog cycle must win over the drop.
    req_valid = 4'b0100;
    log_ready = 1'b0;
    cycle();
    req_valid = '0;
    repeat (TMO - 1) cycle();
    log_ready = 1'b1;
    repeat (3) cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      log_ready = ($urandom % 4) != 0;
      randomize_payload();
      cycle();
    end

    // Reset in the middle of SEND, then the first event restarts at seq 0
    // from requester 0.
    req_valid = 4'b1000;
    log_ready = 1'b0;
    while (!m_busy) cycle();
    check("pre_rst_log_valid", log_valid, 1'b1);
    req_valid = 4'b1111;
    do_reset();
    log_ready = 1'b1;
    dut_grants.delete();
    for (int i = 0; i < 4; i++) begin
      randomize_payload();
      cycle();
    end
    check("post_rst_first_grant", dut_grants[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/audit_event_arbiter.md
AUDIT_EVENT_ARBITER -- requirements
Module: audit_event_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_REQ, 4, number of requesters (2..8); TIMEOUT_CYC, 1024, SEND watchdog limit in cycles.
REQ-002 SHALL use one clock and one reset; reset is asynchronous and active-low; ports in order: clk (in, 1) is the single clock, rising edge; rst_n (in, 1) is the asynchronous active-low reset.
REQ-003 SHALL have ports (name, direction, width, meaning): req_valid (in, NUM_REQ) per-requester event pending; req_ready (out, NUM_REQ) one-hot grant/accept.
REQ-004 SHALL have ports req_did (in, NUM_REQ*128), req_data (in, NUM_REQ*256) and req_res (in, NUM_REQ*256); each is the packed per-requester payload, slot i at [i*W +: W].
REQ-005 SHALL have ports log_valid (out, 1), log_ready (in, 1); log_did (out, 128), log_data (out, 256), log_res (out, 256) towards the audit logging engine.
REQ-006 SHALL have ports log_src (out, 3) winning requester index; log_seq (out, 32) event sequence number; log_timestamp (out, 64) grant-time cycle count; busy (out, 1) high when not IDLE.
REQ-007 SHALL have ports timeout_pulse (out, 1) and drop_count (out, 16); see Configuration.

Function
REQ-008 SHALL implement the FSM states IDLE and SEND; in IDLE with any req_valid set, it SHALL grant exactly one requester and go to SEND on the next edge.
REQ-009 SHALL drive req_ready[w]=1 combinationally in IDLE for winner w only, for exactly that one cycle; payload slot w, w, ts_cnt and seq_cnt SHALL be registered on that edge.
REQ-010 SHALL select the winner round-robin: search starts at rr_ptr, lowest index at or after rr_ptr wins, with wrap-around; rr_ptr SHALL become (w+1) mod NUM_REQ at grant.
REQ-011 SHALL hold log_valid=1 in SEND with log_* stable until log_ready=1; on the handshake edge it SHALL return to IDLE, increment seq_cnt and drop log_valid.
REQ-012 SHALL give minimum event spacing of 2 cycles (grant, send) and zero-cycle latency on log_valid after grant edge; log_ready already high yields a handshake on the first SEND cycle.
REQ-013 SHALL keep ts_cnt a free-running 64-bit counter from reset; it SHALL wrap 2^64-1 -> 0.
REQ-014 SHALL wrap seq_cnt 0xFFFF_FFFF -> 0 without stalling.
REQ-015 SHALL NOT give req_valid stickiness: a requester deasserting before grant is simply skipped; req_valid in SEND SHALL be ignored (req_ready all 0).
REQ-016 SHALL keep log_* at last values in IDLE; they are don't-care when log_valid=0.

Reset
REQ-017 On rst_n low, at any time including mid-SEND, the block SHALL asynchronously force: state IDLE, log_valid 0, req_ready 0, rr_ptr 0, seq_cnt 0, ts_cnt 0, log_* 0, log_src 0, busy 0, timeout_pulse 0, drop_count 0; any in-flight event SHALL be discarded.
REQ-018 SHALL make its first grant possible on the first rising edge after rst_n rises.

Configuration
REQ-019 SHALL support AUDIT_ARB_TIMEOUT_EN; when defined, SEND counts cycles, and at TIMEOUT_CYC cycles without log_ready the event is dropped: return to IDLE, pulse timeout_pulse for 1 cycle, drop_count++ (saturating at 0xFFFF), seq_cnt NOT incremented.
REQ-020 When AUDIT_ARB_TIMEOUT_EN is defined and log_ready arrives in the same cycle the watchdog expires, the handshake SHALL win and no drop is counted.
REQ-021 When AUDIT_ARB_TIMEOUT_EN is undefined, SEND SHALL wait indefinitely, and timeout_pulse and drop_count SHALL be tied to 0.

Verification
REQ-022 SHALL cover single request: req_valid=4'b0100, log_ready=1 -> req_ready=4'b0100 for 1 cycle, next cycle log_valid=1, log_src=2, log_seq=0, then seq=1.
REQ-023 SHALL cover all-request fairness: req_valid=4'b1111 held, log_ready=1 -> grant order 0,1,2,3,0, log_seq 0..4, one event per 2 cycles.
REQ-024 SHALL cover backpressure: log_ready=0 for 10 cycles in SEND -> log_valid and log_* stable, req_ready=0, busy=1; log_ready=1 -> handshake, IDLE.
REQ-025 SHALL cover wrap: seq_cnt forced to 0xFFFF_FFFF -> event carries 0xFFFF_FFFF, next event carries 0.
REQ-026 SHALL cover reset mid-SEND: rst_n low during log_valid=1 -> log_valid=0 immediately, after release first event has log_seq=0, rr_ptr=0.
REQ-027 SHALL cover timeout with AUDIT_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: log_ready=0 -> after 16 SEND cycles timeout_pulse=1, drop_count=1, next event reuses same log_seq.
